turn_sequencer: RTL
===================

// Module: turn_sequencer
// PURPOSE
//  Upstream of the win checker. Debounces the player "flip" button, latches the chosen tile
//  number, and emits the per-turn T/N/B triple the win checker consumes. Samples the win flag
//  and the tile-match flag one cycle later, then either keeps, advances or ends the turn.
//  Owns turn order for up to 4 players and the game-over latch.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  stable-high cycles before a press is accepted (1 ms at 50 MHz)
//  CNT_W            16     debounce counter width; must hold DEBOUNCE_CYCLES
//  NUM_PLAYERS      4      active players, 2..4; turn wraps to 0 after NUM_PLAYERS-1
//  NUM_TILES        24     valid tile numbers are 0..NUM_TILES-1 (NUM_TILES <= 32)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-low reset
//  btn_raw    in   1  raw flip push-button, asynchronous to clk, active-high
//  sel        in   5  tile number selected on switches, sampled on accepted press
//  hit        in   1  flipped card matches target tile; valid in EVAL
//  W          in   1  win flag from win checker; valid in EVAL
//  T          out  2  current player (turn)
//  N          out  5  latched tile number of current flip
//  B          out  1  one-cycle flip strobe to win checker
//  sel_err    out  1  one-cycle pulse: accepted press with sel >= NUM_TILES
//  game_over  out  1  sticky; set when a win is sampled
//  winner     out  2  player that won; valid while game_over=1
// BEHAVIOUR
//  - Reset (rst=0, async): T=0, N=0, B=0, sel_err=0, game_over=0, winner=0, state=IDLE,
//    debounce counter and synchronisers cleared. Reset mid-debounce or mid-EVAL discards it.
//  - btn_raw: 2-FF synchroniser; counter counts while synced level differs from the debounced
//    level, clears when equal; at DEBOUNCE_CYCLES the debounced level toggles. press = 0->1 edge
//    of debounced level, one cycle wide. Release needs no action.
//  - FSM states: IDLE, EVAL, DONE (encoding in shared header).
//    IDLE: on press with sel < NUM_TILES: N<=sel, B<=1 for exactly one cycle, ->EVAL.
//          on press with sel >= NUM_TILES: sel_err<=1 one cycle, N/T unchanged, stay IDLE.
//    EVAL: entered the cycle B is high; W/hit sampled on the following edge (one cycle after
//          B, giving the win checker's counters one edge to update). Priority:
//          W=1 -> winner<=T, game_over<=1, ->DONE;
//          else hit=1 -> T unchanged, ->IDLE; else T<=(T==NUM_PLAYERS-1)?0:T+1, ->IDLE.
//    DONE: all presses ignored, B stays 0, outputs frozen; only rst exits.
//  - Presses arriving while in EVAL or DONE are dropped, not queued.
//  - Flip latency: press edge -> B high next cycle; B -> T update one cycle later.
//  - Simultaneous W=1 and hit=0: win takes priority, T does not advance.
//  - B is never high on two consecutive cycles; N is stable from B until next accepted press.
// STRUCTURE
//  - Shared header game_defs.vh: FSM state encodings, PLAYER_W=2, TILE_W=5, default
//    NUM_PLAYERS/NUM_TILES; the win checker includes the same header.
//  - One sub-module: btn_debounce (sync + counter + rising-edge pulse), params DEBOUNCE_CYCLES,
//    CNT_W; ports clk, rst, btn_raw, press. turn_sequencer holds the FSM and registers.
// TESTING  (sim with DEBOUNCE_CYCLES=4)
//  - Reset: hold rst=0 with btn_raw=1, sel=7 -> T=0,N=0,B=0,game_over=0; release -> no B.
//  - Bounce: btn_raw toggles every 2 cycles for 20 cycles then holds 1, sel=5 -> exactly one
//    B pulse, N=5, T=0.
//  - Miss: T=0, sel=3, press, hit=0, W=0 -> B 1 cycle, N=3, then T=1; repeat from T=3 with
//    NUM_PLAYERS=4 -> T wraps to 0; NUM_PLAYERS=3 from T=2 -> T=0.
//  - Hit: T=2, press sel=9, hit=1 -> N=9, T stays 2, back to IDLE, next press accepted.
//  - Win: T=1, press, W=1 and hit=0 in EVAL -> game_over=1, winner=1, T=1; further presses
//    -> no B; rst=0 -> all cleared.
//  - Bad sel: sel=30 with NUM_TILES=24, press -> sel_err 1 cycle, B=0, N unchanged;
//    press during EVAL -> dropped (single B total).

Source files
------------

// File: rtl/turn_sequencer_pkg.sv
// ============================================================================
// Module : turn_sequencer_pkg
// Brief  : Shared turn/tile widths, default game size and FSM state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package turn_sequencer_pkg;

    localparam int PLAYER_W        = 2;
    localparam int TILE_W          = 5;
    localparam int DEF_NUM_PLAYERS = 4;
    localparam int DEF_NUM_TILES   = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Turn order wraps to player 0 after the last active player.
    function automatic logic [PLAYER_W-1:0] next_player(
        input logic [PLAYER_W-1:0] cur,
        input logic [PLAYER_W-1:0] last
    );
        return (cur == last) ? '0 : cur + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/turn_sequencer_btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Brief  : 2-FF synchroniser, level debounce counter and rising-edge press pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Any cycle agreeing with the debounced level restarts the count.
            if (r_sync2 != r_level) begin
                if (r_cnt == C_LAST) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = r_level & ~r_level_d;

endmodule

`default_nettype wire

// File: rtl/turn_sequencer.sv
// ============================================================================
// Module : turn_sequencer
// Brief  : Flip-button debounce, tile latch, T/N/B strobe and turn/win control.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module turn_sequencer
    import turn_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int NUM_PLAYERS     = DEF_NUM_PLAYERS,
    parameter int NUM_TILES       = DEF_NUM_TILES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_raw,
    input  logic [TILE_W-1:0]   sel,
    input  logic                hit,
    input  logic                W,
    output logic [PLAYER_W-1:0] T,
    output logic [TILE_W-1:0]   N,
    output logic                B,
    output logic                sel_err,
    output logic                game_over,
    output logic [PLAYER_W-1:0] winner
);

    localparam logic [PLAYER_W-1:0] C_LAST_PLAYER = PLAYER_W'(NUM_PLAYERS - 1);
    localparam logic [TILE_W:0]     C_NUM_TILES   = (TILE_W + 1)'(NUM_TILES);

    logic w_press;
    logic w_sel_ok;

    state_t              r_state,     w_state_nxt;
    logic [PLAYER_W-1:0] r_t,         w_t_nxt;
    logic [TILE_W-1:0]   r_n,         w_n_nxt;
    logic                r_b,         w_b_nxt;
    logic                r_sel_err,   w_sel_err_nxt;
    logic                r_game_over, w_game_over_nxt;
    logic [PLAYER_W-1:0] r_winner,    w_winner_nxt;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .press   (w_press)
    );

    assign w_sel_ok = ({1'b0, sel} < C_NUM_TILES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_t         <= '0;
            r_n         <= '0;
            r_b         <= 1'b0;
            r_sel_err   <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_t         <= w_t_nxt;
            r_n         <= w_n_nxt;
            r_b         <= w_b_nxt;
            r_sel_err   <= w_sel_err_nxt;
            r_game_over <= w_game_over_nxt;
            r_winner    <= w_winner_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_t_nxt         = r_t;
        w_n_nxt         = r_n;
        w_b_nxt         = 1'b0;
        w_sel_err_nxt   = 1'b0;
        w_game_over_nxt = r_game_over;
        w_winner_nxt    = r_winner;

        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    if (w_sel_ok) begin
                        w_n_nxt     = sel;
                        w_b_nxt     = 1'b1;
                        w_state_nxt = ST_EVAL;
                    end else begin
                        w_sel_err_nxt = 1'b1;
                    end
                end
            end
            // EVAL lasts exactly the B cycle; W/hit are taken on its closing edge.
            ST_EVAL: begin
                if (W) begin
                    w_winner_nxt    = r_t;
                    w_game_over_nxt = 1'b1;
                    w_state_nxt     = ST_DONE;
                end else begin
                    if (!hit) begin
                        w_t_nxt = next_player(r_t, C_LAST_PLAYER);
                    end
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign T         = r_t;
    assign N         = r_n;
    assign B         = r_b;
    assign sel_err   = r_sel_err;
    assign game_over = r_game_over;
    assign winner    = r_winner;

endmodule

`default_nettype wire
